// File: rtl/ram_burst_reader.sv
// Burst read controller for a single-port RAM with 1- or 2-cycle read latency.
// It issues credit-limited reads and returns the words on a valid/ready stream with a last flag.
module ram_burst_reader #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDITH = 32,
  parameter int PIPE        = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH:0]    len,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDITH-1:0] ram_din,
  output logic                   ram_pipen,
  input  logic [DATA_WIDITH-1:0] ram_dout,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDITH-1:0] m_data,
  output logic                   m_last
);

  localparam int LAT   = PIPE + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + LAT + 1);

  if (FIFO_DEPTH < 2) begin : g_depth_check
    $error("ram_burst_reader: FIFO_DEPTH must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                  state_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ADDR_WIDTH:0]     len_reg;
  logic [ADDR_WIDTH:0]     issued_reg;

  logic                    tag_v_reg [LAT];
  logic                    tag_l_reg [LAT];

  logic [DATA_WIDITH-1:0]  fifo_data_mem [FIFO_DEPTH];
  logic                    fifo_last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;

  logic [CNT_W-1:0]        inflight;
  logic                    credit_ok;
  logic                    issue;
  logic                    issue_last;
  logic                    fifo_wr;
  logic                    fifo_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads already issued but not yet in the FIFO still hold a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CNT_W'(tag_v_reg[i]);
    end
  end

  assign credit_ok  = (count_reg + inflight) < CNT_W'(FIFO_DEPTH);
  assign issue      = (state_reg == RUN) && credit_ok;
  assign issue_last = issue && (issued_reg == len_reg - 1'b1);
  assign fifo_wr    = tag_v_reg[LAT-1];
  assign fifo_rd    = m_valid && m_ready;

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign ram_en    = issue;
  assign ram_we    = 1'b0;
  assign ram_addr  = addr_reg;
  assign ram_din   = '0;
  assign ram_pipen = (PIPE != 0);

  assign m_valid = (count_reg != '0);
  assign m_data  = fifo_data_mem[rd_ptr_reg];
  assign m_last  = fifo_last_mem[rd_ptr_reg] && m_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      addr_reg   <= '0;
      len_reg    <= '0;
      issued_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy_reg   <= 1'b1;
            addr_reg   <= base_addr;
            len_reg    <= len;
            issued_reg <= '0;
            if (len == '0) begin
              state_reg <= FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_reg   <= addr_reg + 1'b1;
            issued_reg <= issued_reg + 1'b1;
            if (issue_last) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_rd && m_last) begin
            state_reg <= FIN;
            done_reg  <= 1'b1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag pipeline mirrors the RAM latency so only words we asked for are captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        tag_v_reg[i] <= 1'b0;
        tag_l_reg[i] <= 1'b0;
      end
    end else begin
      tag_v_reg[0] <= issue;
      tag_l_reg[0] <= issue_last;
      for (int i = 1; i < LAT; i++) begin
        tag_v_reg[i] <= tag_v_reg[i-1];
        tag_l_reg[i] <= tag_l_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr && !rst) begin
      fifo_data_mem[wr_ptr_reg] <= ram_dout;
      fifo_last_mem[wr_ptr_reg] <= tag_l_reg[LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (fifo_rd) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The credit rule must make an overflowing write impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && !fifo_rd && (count_reg == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: PIPE=0 and PIPE=1 instances share stimulus, each with its own RAM
// model, expected-word queue and monitor.
module tb_ram_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] len = '0;
  logic        m_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic        busy, done, ram_en, ram_we, ram_pipen, m_valid, m_last;
    logic [10:0] ram_addr;
    logic [31:0] ram_din, ram_dout, m_data;
    logic [31:0] mem [0:2047];
    logic [31:0] r1 = '0;
    logic [31:0] r2 = '0;

    logic [32:0] exp_q [$];
    logic [10:0] addr_q [$];
    int first_en = -1, first_v = -1, last_acc = -1, done_cyc = -1, done_cnt = 0;
    int outst = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = '0;

    ram_burst_reader #(
      .ADDR_WIDTH(11), .DATA_WIDITH(32), .PIPE(gi), .FIFO_DEPTH(4)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_pipen(ram_pipen), .ram_dout(ram_dout),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    // RAM model: output forced to 0 on cycles without en, optional extra output register.
    initial for (int i = 0; i < 2048; i++) mem[i] = i;
    always @(posedge clk) begin
      r1 <= ram_en ? mem[ram_addr] : 32'h0;
      r2 <= r1;
    end
    assign ram_dout = ram_pipen ? r2 : r1;

    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
        addr_q.delete();
        outst = 0;
        prev_stall = 1'b0;
      end else begin
        if (start && !busy) begin
          first_en = -1; first_v = -1; last_acc = -1; done_cyc = -1; done_cnt = 0;
        end
        if (ram_en) begin
          outst++;
          chk($sformatf("u%0d_outstanding_le4", gi), 64'(outst <= 4), 64'd1);
          if (addr_q.size() == 0) begin
            chk($sformatf("u%0d_unexpected_read", gi), 64'(ram_addr), 64'h7fffffff);
          end else begin
            chk($sformatf("u%0d_ram_addr", gi), 64'(ram_addr), 64'(addr_q.pop_front()));
          end
          if (first_en < 0) first_en = cyc;
        end
        if (m_valid && first_v < 0) first_v = cyc;
        if (prev_stall) chk($sformatf("u%0d_hold", gi), 64'({m_last, m_data}), 64'(prev_word));
        if (m_valid && m_ready) begin
          outst--;
          if (exp_q.size() == 0) begin
            chk($sformatf("u%0d_unexpected_word", gi), 64'({m_last, m_data}), 64'h1ffffffff);
          end else begin
            chk($sformatf("u%0d_word", gi), 64'({m_last, m_data}), 64'(exp_q.pop_front()));
          end
          $display("u%0d cycle %0d word %h last %0d", gi, cyc, m_data, m_last);
          if (m_last) last_acc = cyc;
        end
        prev_stall = m_valid && !m_ready;
        prev_word = {m_last, m_data};
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic issue(input logic [10:0] b, input logic [11:0] l);
    logic [10:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 11'(i);
      g_inst[0].exp_q.push_back({(i == int'(l) - 1), 21'b0, a});
      g_inst[1].exp_q.push_back({(i == int'(l) - 1), 21'b0, a});
      g_inst[0].addr_q.push_back(a);
      g_inst[1].addr_q.push_back(a);
    end
    @(posedge clk);
    #2;
    start = 1'b1; base_addr = b; len = l; t_start = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(g_inst[0].done_cnt > 0 && g_inst[1].done_cnt > 0) && n < budget) begin
      step(1);
      n++;
    end
    chk("done_within_budget", 64'(n < budget), 64'd1);
    step(3);
  endtask

  task automatic check_end(input string tag, input int qsz, input int dcnt);
    chk({tag, "_queue_empty"}, 64'(qsz), 64'd0);
    chk({tag, "_done_once"}, 64'(dcnt), 64'd1);
  endtask

  task automatic check_timing(input string tag, input int p, input int fe, input int fv,
                              input int la, input int dc);
    chk({tag, "_first_en_cycle"}, 64'(fe - t_start), 64'd1);
    chk({tag, "_first_valid_cycle"}, 64'(fv - t_start), 64'(3 + p));
    chk({tag, "_last_accept_cycle"}, 64'(la - t_start), 64'(6 + p));
    chk({tag, "_done_cycle"}, 64'(dc - t_start), 64'(7 + p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    // Reset / idle values
    chk("u0_reset_ctrl", 64'({g_inst[0].busy, g_inst[0].done, g_inst[0].ram_en,
                              g_inst[0].m_valid, g_inst[0].m_last}), 64'd0);
    chk("u1_reset_ctrl", 64'({g_inst[1].busy, g_inst[1].done, g_inst[1].ram_en,
                              g_inst[1].m_valid, g_inst[1].m_last}), 64'd0);
    chk("u0_reset_addr", 64'(g_inst[0].ram_addr), 64'd0);
    chk("u1_reset_addr", 64'(g_inst[1].ram_addr), 64'd0);
    chk("u0_pipen", 64'(g_inst[0].ram_pipen), 64'd0);
    chk("u1_pipen", 64'(g_inst[1].ram_pipen), 64'd1);
    chk("u0_we_din", 64'({g_inst[0].ram_we, g_inst[0].ram_din}), 64'd0);
    chk("u1_we_din", 64'({g_inst[1].ram_we, g_inst[1].ram_din}), 64'd0);

    // Basic burst, exact timing for both latencies
    issue(11'h010, 12'd4);
    wait_done(100);
    check_timing("u0", 0, g_inst[0].first_en, g_inst[0].first_v, g_inst[0].last_acc,
                 g_inst[0].done_cyc);
    check_timing("u1", 1, g_inst[1].first_en, g_inst[1].first_v, g_inst[1].last_acc,
                 g_inst[1].done_cyc);
    check_end("u0_basic", g_inst[0].exp_q.size(), g_inst[0].done_cnt);
    check_end("u1_basic", g_inst[1].exp_q.size(), g_inst[1].done_cnt);
    chk("u1_pipen_after", 64'(g_inst[1].ram_pipen), 64'd1);

    // Address wrap
    issue(11'h7FE, 12'd4);
    wait_done(100);
    check_end("u0_wrap", g_inst[0].exp_q.size(), g_inst[0].done_cnt);
    check_end("u1_wrap", g_inst[1].exp_q.size(), g_inst[1].done_cnt);

    // Back-pressure for 10 cycles, with an ignored start while busy
    issue(11'h100, 12'd12);
    step(3);
    m_ready = 1'b0;
    step(5);
    start = 1'b1; base_addr = 11'h555; len = 12'd5;
    step(1);
    start = 1'b0;
    step(4);
    m_ready = 1'b1;
    wait_done(200);
    check_end("u0_stall", g_inst[0].exp_q.size(), g_inst[0].done_cnt);
    check_end("u1_stall", g_inst[1].exp_q.size(), g_inst[1].done_cnt);

    // Zero-length burst
    issue(11'h020, 12'd0);
    wait_done(50);
    check_end("u0_len0", g_inst[0].exp_q.size(), g_inst[0].done_cnt);
    check_end("u1_len0", g_inst[1].exp_q.size(), g_inst[1].done_cnt);
    chk("u0_len0_done_window", 64'((g_inst[0].done_cyc - t_start) inside {[1:2]}), 64'd1);
    chk("u1_len0_done_window", 64'((g_inst[1].done_cyc - t_start) inside {[1:2]}), 64'd1);
    chk("u0_len0_no_en", 64'(g_inst[0].first_en), 64'hffffffffffffffff);
    chk("u1_len0_no_valid", 64'(g_inst[1].first_v), 64'hffffffffffffffff);

    // Reset with three reads in flight
    m_ready = 1'b0;
    issue(11'h200, 12'd8);
    step(2);
    rst = 1'b1;
    step(1);
    chk("u0_midrst_ctrl", 64'({g_inst[0].busy, g_inst[0].done, g_inst[0].ram_en,
                               g_inst[0].m_valid, g_inst[0].m_last}), 64'd0);
    chk("u1_midrst_ctrl", 64'({g_inst[1].busy, g_inst[1].done, g_inst[1].ram_en,
                               g_inst[1].m_valid, g_inst[1].m_last}), 64'd0);
    chk("u0_midrst_addr", 64'(g_inst[0].ram_addr), 64'd0);
    chk("u1_midrst_addr", 64'(g_inst[1].ram_addr), 64'd0);
    rst = 1'b0;
    step(8);
    chk("u0_no_done_after_rst", 64'(g_inst[0].done_cnt), 64'd0);
    chk("u1_no_done_after_rst", 64'(g_inst[1].done_cnt), 64'd0);
    chk("u0_no_stale_valid", 64'(g_inst[0].m_valid), 64'd0);
    chk("u1_no_stale_valid", 64'(g_inst[1].m_valid), 64'd0);
    m_ready = 1'b1;
    issue(11'h300, 12'd3);
    wait_done(100);
    check_end("u0_post_rst", g_inst[0].exp_q.size(), g_inst[0].done_cnt);
    check_end("u1_post_rst", g_inst[1].exp_q.size(), g_inst[1].done_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
